// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises RxD, samples each bit at mid-point, checks the stop bit
// and holds the byte in a single-entry register with a valid/ready handshake.
module uart_receiver #(
    parameter int unsigned clk_freq     = 50_000_000,
    parameter int unsigned baud_rate    = 115200,
    parameter int unsigned div_counter  = clk_freq / baud_rate,
    parameter int unsigned half_counter = div_counter / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] RxData,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       framing_error,
    output logic       overrun
);

    localparam int unsigned CNT_W = $clog2(div_counter);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(div_counter - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_counter - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    logic             rxd_meta;
    logic             rxd_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_index;
    logic [7:0]       shift;

    // Two-flop synchroniser; the idle line level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= RxD;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_index     <= '0;
            shift         <= '0;
            RxData        <= '0;
            rx_valid      <= 1'b0;
            busy          <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state     <= DATA;
                            bit_index <= '0;
                        end else begin
                            // Start bit did not survive to mid-bit: treat as a glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == DIV_LAST) begin
                        cnt              <= '0;
                        shift[bit_index] <= rxd_s;
                        bit_index        <= bit_index + 3'd1;
                        if (bit_index == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            // A new byte overwrites an unread one unless it is consumed on this edge.
                            RxData   <= shift;
                            rx_valid <= 1'b1;
                            overrun  <= rx_valid && !rx_ready;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    // Hold off until a break releases so it is not seen as a new start bit.
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
